// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU front end: opcode values, instruction
// field positions and the fetch/issue state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REGRD,
    ST_ISSUE,
    ST_HALTED
  } fi_state_t;

  function automatic logic [3:0] opc_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_issue_pc_reg.sv
// Program counter: reset load, wrapping increment, JMP load and redirect load,
// with priority redirect > JMP > increment.
module pc_reg #(
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              jmp_load,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              redirect_load,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_load) begin
      pc <= redirect_target;
    end else if (jmp_load) begin
      pc <= jmp_target;
    end else if (inc) begin
      pc <= pc + ONE;
    end
  end

endmodule

// File: rtl/fetch_issue.sv
// Fetch/decode/register-read front end: fetches one instruction at a time,
// reads its two sources and hands the bundle to execute.
module fetch_issue
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [3:0]        rf_raddr1,
  output logic [3:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [ADDR_W-1:0] issue_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  // Handshake: the bundle transfers on a cycle where issue_valid && issue_ready;
  // while issue_valid is high without ready, every bundle field holds stable.

  fi_state_t         state;
  logic [DATA_W-1:0] instr;
  logic              redirect_pending;
  logic [ADDR_W-1:0] pending_pc;
  logic [ADDR_W-1:0] pc;

  logic              handshake;
  logic              halt_xfer;
  logic              drop_fetch;
  logic              pc_redirect;
  logic [ADDR_W-1:0] pc_target;
  logic              pc_inc;
  logic              pc_jmp;

  assign handshake  = issue_valid && issue_ready;
  assign halt_xfer  = (state == ST_ISSUE) && handshake && (opcode == OP_HALT);
  assign drop_fetch = (state == ST_FETCH) && imem_ack && (redirect_valid || redirect_pending);
  assign pc_inc     = (state == ST_REGRD);
  assign pc_jmp     = (state == ST_REGRD) && (opc_of(instr) == OP_JMP);
  assign imem_addr  = pc;

  always_comb begin
    pc_redirect = 1'b0;
    pc_target   = redirect_pc;
    case (state)
      ST_FETCH: begin
        pc_redirect = drop_fetch;
        pc_target   = redirect_valid ? redirect_pc : pending_pc;
      end
      ST_REGRD: pc_redirect = redirect_valid;
      ST_ISSUE: pc_redirect = redirect_valid && !halt_xfer;
      default:  pc_redirect = 1'b0;
    endcase
  end

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .inc            (pc_inc),
    .jmp_load       (pc_jmp),
    .jmp_target     (instr[ADDR_W-1:0]),
    .redirect_load  (pc_redirect),
    .redirect_target(pc_target),
    .pc             (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      imem_req         <= 1'b0;
      instr            <= '0;
      rf_raddr1        <= '0;
      rf_raddr2        <= '0;
      issue_valid      <= 1'b0;
      opcode           <= '0;
      operand          <= '0;
      read_data1       <= '0;
      read_data2       <= '0;
      issue_pc         <= '0;
      halted           <= 1'b0;
      redirect_pending <= 1'b0;
      pending_pc       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            redirect_pending <= 1'b0;
            // A redirected fetch is never withdrawn; its data is dropped and
            // the request re-issues at the new pc with imem_req still high.
            if (!drop_fetch) begin
              instr     <= imem_rdata;
              rf_raddr1 <= imem_rdata[RS1_MSB:RS1_LSB];
              rf_raddr2 <= imem_rdata[RS2_MSB:RS2_LSB];
              imem_req  <= 1'b0;
              state     <= ST_REGRD;
            end
          end else if (redirect_valid) begin
            redirect_pending <= 1'b1;
            pending_pc       <= redirect_pc;
          end
        end
        ST_REGRD: begin
          if (redirect_valid) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end else begin
            read_data1  <= rf_rdata1;
            read_data2  <= rf_rdata2;
            opcode      <= opc_of(instr);
            operand     <= instr[ADDR_W-1:0];
            issue_pc    <= pc;
            issue_valid <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (handshake) begin
            issue_valid <= 1'b0;
            if (opcode == OP_HALT) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else begin
              state    <= ST_FETCH;
              imem_req <= 1'b1;
            end
          end else if (redirect_valid) begin
            issue_valid <= 1'b0;
            state       <= ST_FETCH;
            imem_req    <= 1'b1;
          end
        end
        ST_HALTED: begin
          halted <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_issue.sv
// Bench for fetch_issue: table of straight-line fetches plus stall, redirect,
// wrap, halt and reset sequences, checked through an issue scoreboard.
module tb_fetch_issue;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] instr;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [11:0] next;
  } vec_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] opnd;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [11:0] pc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'hDEAD;
  logic [3:0]  rf_raddr1, rf_raddr2;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic [15:0] read_data1, read_data2;
  logic [11:0] issue_pc;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        halted;

  logic [15:0] mem [0:4095];
  logic [15:0] rf [16];
  bundle_t     exp_q [$];
  vec_t        tbl [6];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int hs_count = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int last_ack_cyc = 0;
  int last_rise = 0;
  int last_req_cyc = 0;
  logic prev_valid = 1'b0;

  fetch_issue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .rf_raddr1     (rf_raddr1),
    .rf_raddr2     (rf_raddr2),
    .rf_rdata1     (rf_rdata1),
    .rf_rdata2     (rf_rdata2),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .opcode        (opcode),
    .operand       (operand),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .issue_pc      (issue_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted)
  );

  // Clock, cycle counter, register file read port
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // Instruction memory responder with programmable ack delay
  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      wait_cnt   = 0;
    end else if (wait_cnt >= ack_delay) begin
      imem_ack     = 1'b1;
      imem_rdata   = mem[imem_addr];
      wait_cnt     = 0;
      last_ack_cyc = cyc;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      wait_cnt++;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each transfer against the oldest expected bundle
  always @(negedge clk) begin
    if (rst_n && issue_valid && !prev_valid) last_rise = cyc;
    prev_valid = issue_valid;
    if (rst_n && issue_valid && issue_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got pc %h opcode %h expected no transfer", issue_pc, opcode);
      end else begin
        bundle_t e;
        e = exp_q.pop_front();
        check("sb_opcode", {12'h0, opcode}, {12'h0, e.op});
        check("sb_operand", {4'h0, operand}, {4'h0, e.opnd});
        check("sb_read_data1", read_data1, e.d1);
        check("sb_read_data2", read_data2, e.d2);
        check("sb_issue_pc", {4'h0, issue_pc}, {4'h0, e.pc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event within budget", name);
  endtask

  task automatic wait_hs(input int target, input string name);
    int n = 0;
    while (hs_count < target && n < 100) begin
      tick();
      n++;
    end
    if (hs_count < target) timeout(name);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 100) begin
      tick();
      n++;
    end
    if (!imem_req) timeout(name);
    last_req_cyc = cyc;
  endtask

  task automatic push_vec(input vec_t v);
    bundle_t b;
    logic [15:0] ins;
    ins    = v.instr;
    b.op   = ins[15:12];
    b.opnd = ins[11:0];
    b.d1   = v.rd1;
    b.d2   = v.rd2;
    b.pc   = v.addr;
    exp_q.push_back(b);
  endtask

  // Expect one issue of v, then the next fetch at v.next
  task automatic run_vec(input vec_t v, input string name);
    int target;
    target    = hs_count + 1;
    ack_delay = $urandom_range(0, 2);
    push_vec(v);
    wait_hs(target, name);
    wait_req(name);
    check(name, {4'h0, imem_addr}, {4'h0, v.next});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v200, vfff, vabd, vhlt;
    bundle_t b;
    int n;
    int hs0;

    tbl[0] = '{12'h000, 16'h1023, 16'h00AA, 16'h0055, 12'h001};
    tbl[1] = '{12'h001, 16'h2045, 16'h0404, 16'h0505, 12'h002};
    tbl[2] = '{12'h002, 16'h3167, 16'h0606, 16'h0707, 12'h003};
    tbl[3] = '{12'h003, 16'h0089, 16'h0808, 16'h0909, 12'h004};
    tbl[4] = '{12'h004, 16'h7ABC, 16'h0B0B, 16'h0C0C, 12'hABC};
    tbl[5] = '{12'hABC, 16'hE5D2, 16'h0D0D, 16'h00AA, 12'hABD};
    vabd   = '{12'hABD, 16'h6123, 16'h00AA, 16'h0055, 12'hABE};
    v200   = '{12'h200, 16'h7FFF, 16'h0F0F, 16'h0F0F, 12'hFFF};
    vfff   = '{12'hFFF, 16'h3456, 16'h0505, 16'h0606, 12'h000};
    vhlt   = '{12'h300, 16'hF000, 16'h0000, 16'h0000, 12'h000};

    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) rf[i] = 16'(16'h0101 * i);
    rf[2] = 16'h00AA;
    rf[3] = 16'h0055;
    for (int i = 0; i < 6; i++) mem[tbl[i].addr] = tbl[i].instr;
    mem[12'hABD] = vabd.instr;
    mem[12'hABE] = 16'h9999;
    mem[12'h100] = 16'h8888;
    mem[12'h200] = v200.instr;
    mem[12'hFFF] = vfff.instr;
    mem[12'h300] = vhlt.instr;

    rst_n          = 1'b0;
    issue_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 12'h000;
    tick();
    tick();
    check("rst_imem_req", {15'h0, imem_req}, 16'h0);
    check("rst_imem_addr", {4'h0, imem_addr}, 16'h0);
    check("rst_issue_valid", {15'h0, issue_valid}, 16'h0);
    check("rst_halted", {15'h0, halted}, 16'h0);
    check("rst_bundle", {opcode, operand} | read_data1 | read_data2 | {4'h0, issue_pc}, 16'h0);
    check("rst_raddr", {8'h0, rf_raddr1, rf_raddr2}, 16'h0);
    rst_n       = 1'b1;
    issue_ready = 1'b1;

    // Straight-line table including JMP
    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d_next_addr", i));
      if (i == 0) begin
        check("latency_ack_to_valid", 16'(last_rise - last_ack_cyc), 16'd2);
        check("latency_ack_to_req", 16'(last_req_cyc - last_ack_cyc), 16'd3);
      end
    end

    // Stall with ready low for 5 cycles
    issue_ready = 1'b0;
    ack_delay   = 0;
    push_vec(vabd);
    hs0 = hs_count;
    n = 0;
    while (!issue_valid && n < 50) begin
      tick();
      n++;
    end
    if (!issue_valid) timeout("stall_wait_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {15'h0, issue_valid}, 16'h1);
      check("stall_req", {15'h0, imem_req}, 16'h0);
      check("stall_bundle_op", {opcode, operand}, vabd.instr);
      check("stall_bundle_d1", read_data1, vabd.rd1);
      check("stall_bundle_d2", read_data2, vabd.rd2);
      check("stall_bundle_pc", {4'h0, issue_pc}, {4'h0, vabd.addr});
    end
    ack_delay   = 3;
    issue_ready = 1'b1;
    tick();
    check("stall_one_transfer", 16'(hs_count - hs0), 16'd1);
    check("stall_valid_drop", {15'h0, issue_valid}, 16'h0);
    check("stall_next_addr", {4'h0, imem_addr}, 16'hABE);

    // Redirect twice during a slow fetch; last target wins, data discarded
    redirect_valid = 1'b1;
    redirect_pc    = 12'h100;
    tick();
    redirect_pc    = 12'h200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("redir_req_held", {15'h0, imem_req}, 16'h1);
      check("redir_addr_held", {4'h0, imem_addr}, 16'hABE);
      tick();
    end
    n = 0;
    while (imem_addr == 12'hABE && n < 20) begin
      tick();
      n++;
    end
    check("redir_req_after", {15'h0, imem_req}, 16'h1);
    check("redir_next_addr", {4'h0, imem_addr}, 16'h200);

    // JMP to 0xFFF, then wrap to 0x000
    run_vec(v200, "jmp_fff_next_addr");
    run_vec(vfff, "wrap_next_addr");

    // Redirect while in register read: instruction dropped
    ack_delay = 0;
    n = 0;
    while (imem_req && n < 20) begin
      tick();
      n++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 12'h300;
    tick();
    redirect_valid = 1'b0;
    check("regrd_redir_valid", {15'h0, issue_valid}, 16'h0);
    check("regrd_redir_req", {15'h0, imem_req}, 16'h1);
    check("regrd_redir_addr", {4'h0, imem_addr}, 16'h300);

    // HALT transfers together with a redirect: halt wins
    issue_ready = 1'b0;
    push_vec(vhlt);
    n = 0;
    while (!issue_valid && n < 50) begin
      tick();
      n++;
    end
    if (!issue_valid) timeout("halt_wait_valid");
    issue_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 12'h123;
    tick();
    redirect_valid = 1'b0;
    check("halt_halted", {15'h0, halted}, 16'h1);
    check("halt_valid", {15'h0, issue_valid}, 16'h0);
    for (int i = 0; i < 20; i++) begin
      check("halt_no_req", {15'h0, imem_req}, 16'h0);
      tick();
    end
    check("halt_still_halted", {15'h0, halted}, 16'h1);

    // Reset from halted restarts fetch at 0x000
    rst_n = 1'b0;
    #1;
    check("rst2_halted", {15'h0, halted}, 16'h0);
    check("rst2_req", {15'h0, imem_req}, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_req("rst2_wait_req");
    check("rst2_first_addr", {4'h0, imem_addr}, 16'h000);
    run_vec(tbl[0], "rst2_next_addr");

    tick();
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    b = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_issue.md
Name: fetch_issue

Overview:
- Front-end stage of the mini CPU: fetches 16-bit instructions from instruction memory and splits them into opcode[15:12] and operand[11:0].
- Reads the two source registers from the register file.
- Presents a fully formed {opcode, operand, read_data1, read_data2} bundle to the execute stage over a valid/ready handshake.
- Owns the PC: sequential increment, unconditional JMP redirect at decode, and external redirect from downstream branch resolution.

Parameters:
ADDR_W, 12, PC / instruction address width (equals operand width)
DATA_W, 16, instruction and register data width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  ADDR_W  fetch address (current PC)
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  DATA_W  fetched instruction
rf_raddr1  output  4  register read address 1 = operand[7:4]
rf_raddr2  output  4  register read address 2 = operand[3:0]
rf_rdata1  input  DATA_W  register data 1, valid one cycle after address
rf_rdata2  input  DATA_W  register data 2, valid one cycle after address
issue_valid  output  1  bundle valid toward execute
issue_ready  input  1  execute accepts bundle
opcode  output  4  issued opcode
operand  output  ADDR_W  issued operand
read_data1  output  DATA_W  issued source 1
read_data2  output  DATA_W  issued source 2
issue_pc  output  ADDR_W  PC of issued instruction
redirect_valid  input  1  downstream branch redirect
redirect_pc  input  ADDR_W  redirect target
halted  output  1  HALT instruction issued; fetch stopped

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; pc = RESET_PC.
  - All outputs 0: imem_req, issue_valid, halted, opcode, operand, read_data1, read_data2, issue_pc, rf_raddr*.
  - redirect_pending = 0.
- All outputs are registered.
- State machine: IDLE -> FETCH -> REGRD -> ISSUE -> FETCH; HALTED is terminal.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - imem_req = 1, imem_addr = pc; both held stable until imem_ack.
  - On ack: latch the instruction, drive rf_raddr1/2 from it, go to REGRD.
  - A same-cycle ack (ack in the first FETCH cycle) is legal.
- REGRD:
  - Capture rf_rdata1/2 into read_data1/2; drive opcode, operand, issue_pc; go to ISSUE.
  - pc update this cycle: JMP (0111) loads pc = operand; every other opcode loads pc = pc+1, wrapping 0xFFF -> 0x000.
- ISSUE:
  - issue_valid = 1; the bundle is held stable until issue_ready.
  - On issue_valid && issue_ready, go to FETCH, or to HALTED if opcode = 1111.
- HALTED: halted = 1, no further fetch; leave only via reset.
- Best-case latency: ack in cycle t; issue_valid at t+2; next imem_req at t+3 if ready is high.
- LOAD (0000) and JMP are issued to execute like every other opcode; the register data is don't-care for them but still sampled.
- Redirect, in any state except HALTED and IDLE:
  - FETCH with a request outstanding:
    - Record redirect_pending and the target.
    - Keep imem_req asserted until ack (the request is never withdrawn).
    - Discard the returned data, set pc = target, and re-enter FETCH.
  - REGRD or ISSUE without handshake: drop the instruction, deassert issue_valid next cycle, set pc = redirect_pc, go to FETCH.
  - ISSUE with issue_valid && issue_ready in the same cycle: the transfer counts, and pc = redirect_pc overrides the sequential/JMP value.
  - If the transferred opcode is HALT, HALTED wins over the redirect.
  - A second redirect while one is pending replaces the target (last wins).
- Reset mid-operation: immediate return to reset values; an outstanding imem request is abandoned.

Decomposition:
- cpu_pkg holds:
  - opcode constants OP_LOAD = 4'b0000, OP_JMP = 4'b0111, OP_HALT = 4'b1111;
  - field positions (OPC_MSB/LSB, RS1, RS2);
  - the fetch_issue state enum.
- One sub-module, pc_reg: the PC register with reset load, increment-with-wrap, JMP/redirect load, and priority redirect > JMP > increment.

Test Plan:
- Reset, then imem returns 0x1023 on its first ack, with rf[2] = 0x00AA and rf[3] = 0x0055 -> imem_addr 0x000; two cycles after ack: issue_valid = 1, opcode 0x1, operand 0x023, read_data1 0x00AA, read_data2 0x0055, issue_pc 0x000; next fetch address 0x001.
- JMP 0x7ABC at pc 0x004 -> issued with opcode 7, operand 0xABC; next imem_addr = 0xABC.
- issue_ready held low for 5 cycles -> issue_valid and all bundle fields stable and no imem_req during the stall; after ready, exactly one transfer.
- pc = 0xFFF with a non-JMP opcode -> next imem_addr = 0x000.
- redirect_valid to 0x200 while imem_ack is delayed 3 cycles -> imem_req stays high until ack; that instruction is never issued; next imem_addr = 0x200.
- HALT 0xF000 issued with ready -> halted = 1, imem_req stays 0 for 20 cycles; asserting rst_n low then high -> halted = 0, fetch restarts at 0x000.
